// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader for the 1 MiB instruction memory
module imem_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [19:0] base_addr,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [19:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [19:0] base;
    logic [31:0] len;
    logic [31:0] cnt;
    logic [31:0] asm_data;
    logic [3:0]  asm_mask;

    logic        xfer;
    logic [31:0] len_full;
    logic [32:0] end_addr;
    logic        last_byte;
    logic        word_done;
    logic [31:0] asm_data_nxt;
    logic [3:0]  asm_mask_nxt;

    // Handshake, length-check and byte-lane merge terms shared by FSM and datapath
    always_comb begin
        xfer         = rx_valid & rx_ready;
        len_full     = {rx_data, len[23:0]};
        end_addr     = {13'b0, base} + {1'b0, len_full};
        last_byte    = (cnt == len - 32'd1);
        word_done    = (cnt[1:0] == 2'd3) | last_byte;
        asm_data_nxt = asm_data | ({24'b0, rx_data} << {cnt[1:0], 3'b000});
        asm_mask_nxt = asm_mask | (4'b0001 << cnt[1:0]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        busy      = 1'b0;
        cpu_hold  = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                cpu_hold = 1'b0;
                if (start) begin
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (xfer && cnt[1:0] == 2'd3) begin
                    if (len_full == 32'd0) begin
                        state_nxt = S_DONE;
                    end else if (end_addr > 33'h0_0010_0000) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (xfer && last_byte) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                err       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Session registers, word assembly and the write-port output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            base      <= '0;
            len       <= '0;
            cnt       <= '0;
            asm_data  <= '0;
            asm_mask  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base     <= {base_addr[19:2], 2'b00};
                        len      <= '0;
                        cnt      <= '0;
                        asm_data <= '0;
                        asm_mask <= '0;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        len[{cnt[1:0], 3'b000} +: 8] <= rx_data;
                        // The payload counter restarts at 0 once the header is in
                        cnt <= (cnt[1:0] == 2'd3) ? 32'd0 : cnt + 32'd1;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        cnt <= cnt + 32'd1;
                        if (word_done) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= base + {cnt[19:2], 2'b00};
                            mem_wdata <= asm_data_nxt;
                            mem_wmask <= asm_mask_nxt;
                            asm_data  <= '0;
                            asm_mask  <= '0;
                        end else begin
                            asm_data  <= asm_data_nxt;
                            asm_mask  <= asm_mask_nxt;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] base_addr;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int ncmp;
    int nfail;

    logic [19:0] qa[$];
    logic [31:0] qd[$];
    logic [3:0]  qm[$];
    int          done_cnt;
    int          err_cnt;

    imem_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every write and pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we) begin
            qa.push_back(mem_addr);
            qd.push_back(mem_wdata);
            qm.push_back(mem_wmask);
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic clear_log();
        qa.delete();
        qd.delete();
        qm.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic start_session(input logic [19:0] b);
        start     = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!rx_ready) begin
            ncmp++;
            nfail++;
            $display("FAIL send_timeout: rx_ready=%b required 1 for byte %h", rx_ready, b);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_len(input logic [31:0] l);
        send_byte(l[7:0]);
        send_byte(l[15:8]);
        send_byte(l[23:16]);
        send_byte(l[31:24]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (cpu_hold && n < 2000) begin
            n++;
            @(negedge clk);
        end
        ncmp++;
        if (cpu_hold !== 1'b0) begin
            nfail++;
            $display("FAIL idle_timeout: cpu_hold=%b required 0", cpu_hold);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        ncmp++;
        if ({rx_ready, mem_we, mem_addr, mem_wdata, mem_wmask, cpu_hold, busy, done, err} !== 62'd0) begin
            nfail++;
            $display("FAIL reset_outputs: got we=%b addr=%h data=%h mask=%h hold=%b busy=%b done=%b err=%b rdy=%b required all 0",
                     mem_we, mem_addr, mem_wdata, mem_wmask, cpu_hold, busy, done, err, rx_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        clear_log();
        start_session(20'h00000);
        send_len(32'd4);
        send_byte(8'h13); send_byte(8'h01); send_byte(8'h40); send_byte(8'h00);
        @(negedge clk);
        ncmp++;
        if ({done, mem_we} !== 2'b11) begin
            nfail++;
            $display("FAIL single_done_we: done=%b mem_we=%b required 1 1", done, mem_we);
        end
        ncmp++;
        if ({mem_addr, mem_wdata, mem_wmask} !== {20'h00000, 32'h00400113, 4'b1111}) begin
            nfail++;
            $display("FAIL single_write: got %h %h %b required 00000 00400113 1111", mem_addr, mem_wdata, mem_wmask);
        end
        @(negedge clk);
        ncmp++;
        if ({cpu_hold, done, mem_we} !== 3'b000) begin
            nfail++;
            $display("FAIL single_hold_fall: hold=%b done=%b we=%b required 0 0 0", cpu_hold, done, mem_we);
        end
        @(posedge clk); #1;
        ncmp++;
        if (qa.size() !== 1) begin
            nfail++;
            $display("FAIL single_count: got %0d writes required 1", qa.size());
        end
    endtask

    task automatic test_partial_tail();
        clear_log();
        start_session(20'h00102);
        send_len(32'd6);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        wait_idle();
        ncmp++;
        if (qa.size() !== 2) begin
            nfail++;
            $display("FAIL tail_count: got %0d writes required 2", qa.size());
        end else begin
            ncmp++;
            if ({qa[0], qd[0], qm[0]} !== {20'h00100, 32'h04030201, 4'b1111}) begin
                nfail++;
                $display("FAIL tail_w0: got %h %h %b required 00100 04030201 1111", qa[0], qd[0], qm[0]);
            end
            ncmp++;
            if ({qa[1], qd[1], qm[1]} !== {20'h00104, 32'h00000605, 4'b0011}) begin
                nfail++;
                $display("FAIL tail_w1: got %h %h %b required 00104 00000605 0011", qa[1], qd[1], qm[1]);
            end
        end
        ncmp++;
        if ({mem_we, mem_addr, mem_wmask} !== {1'b0, 20'h00104, 4'b0011}) begin
            nfail++;
            $display("FAIL tail_hold_regs: got we=%b %h %b required 0 00104 0011", mem_we, mem_addr, mem_wmask);
        end
    endtask

    task automatic test_zero_and_bounds();
        // len 0
        clear_log();
        start_session(20'h00040);
        send_len(32'd0);
        @(negedge clk);
        ncmp++;
        if ({done, mem_we} !== 2'b10) begin
            nfail++;
            $display("FAIL zero_done: done=%b we=%b required 1 0", done, mem_we);
        end
        wait_idle();
        ncmp++;
        if (qa.size() !== 0 || done_cnt !== 1) begin
            nfail++;
            $display("FAIL zero_counts: writes=%0d dones=%0d required 0 1", qa.size(), done_cnt);
        end
        // out of range
        clear_log();
        start_session(20'hFFFFC);
        send_len(32'd8);
        @(negedge clk);
        ncmp++;
        if ({err, done, rx_ready} !== 3'b100) begin
            nfail++;
            $display("FAIL bound_err: err=%b done=%b rdy=%b required 1 0 0", err, done, rx_ready);
        end
        wait_idle();
        ncmp++;
        if (qa.size() !== 0 || err_cnt !== 1 || done_cnt !== 0) begin
            nfail++;
            $display("FAIL bound_err_counts: writes=%0d errs=%0d dones=%0d required 0 1 0", qa.size(), err_cnt, done_cnt);
        end
        // exactly at the top
        clear_log();
        start_session(20'hFFFFC);
        send_len(32'd4);
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        wait_idle();
        ncmp++;
        if (qa.size() !== 1 || done_cnt !== 1 || err_cnt !== 0) begin
            nfail++;
            $display("FAIL bound_ok_counts: writes=%0d dones=%0d errs=%0d required 1 1 0", qa.size(), done_cnt, err_cnt);
        end else begin
            ncmp++;
            if ({qa[0], qd[0], qm[0]} !== {20'hFFFFC, 32'h04030201, 4'b1111}) begin
                nfail++;
                $display("FAIL bound_ok_write: got %h %h %b required FFFFC 04030201 1111", qa[0], qd[0], qm[0]);
            end
        end
    endtask

    task automatic check_nine(input string tag);
        ncmp++;
        if (qa.size() !== 3 || done_cnt !== 1) begin
            nfail++;
            $display("FAIL %s_count: writes=%0d dones=%0d required 3 1", tag, qa.size(), done_cnt);
        end else begin
            ncmp++;
            if ({qa[0], qd[0], qm[0], qa[1], qd[1], qm[1], qa[2], qd[2], qm[2]} !==
                {20'h00200, 32'h14131211, 4'b1111, 20'h00204, 32'h18171615, 4'b1111, 20'h00208, 32'h00000019, 4'b0001}) begin
                nfail++;
                $display("FAIL %s_writes: got %h %h %b / %h %h %b / %h %h %b required 00200 14131211 1111 / 00204 18171615 1111 / 00208 00000019 0001",
                         tag, qa[0], qd[0], qm[0], qa[1], qd[1], qm[1], qa[2], qd[2], qm[2]);
            end
        end
    endtask

    task automatic test_flow_control();
        clear_log();
        start_session(20'h00200);
        send_len(32'd9);
        for (int i = 0; i < 9; i++) send_byte(8'h11 + 8'(i));
        wait_idle();
        check_nine("b2b");

        clear_log();
        start_session(20'h00200);
        send_len(32'd9);
        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            if (i == 3) start_session(20'h00040);
            send_byte(8'h11 + 8'(i));
        end
        wait_idle();
        check_nine("gaps");

        // bytes offered while idle must not be taken
        clear_log();
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ncmp++;
            if ({rx_ready, cpu_hold} !== 2'b00) begin
                nfail++;
                $display("FAIL idle_bytes: rdy=%b hold=%b required 0 0", rx_ready, cpu_hold);
            end
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        ncmp++;
        if (qa.size() !== 0) begin
            nfail++;
            $display("FAIL idle_bytes_writes: got %0d required 0", qa.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        start_session(20'h00000);
        send_len(32'd4);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        ncmp++;
        if ({rx_ready, mem_we, mem_addr, mem_wdata, mem_wmask, cpu_hold, busy, done, err} !== 62'd0) begin
            nfail++;
            $display("FAIL midrst_outputs: got we=%b addr=%h data=%h mask=%h hold=%b busy=%b done=%b err=%b rdy=%b required all 0",
                     mem_we, mem_addr, mem_wdata, mem_wmask, cpu_hold, busy, done, err, rx_ready);
        end
        @(posedge clk); #1;
        ncmp++;
        if (qa.size() !== 0) begin
            nfail++;
            $display("FAIL midrst_writes: got %0d required 0", qa.size());
        end
        start_session(20'h00000);
        send_len(32'd4);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        wait_idle();
        ncmp++;
        if (qa.size() !== 1 || done_cnt !== 1) begin
            nfail++;
            $display("FAIL midrst_after_count: writes=%0d dones=%0d required 1 1", qa.size(), done_cnt);
        end else begin
            ncmp++;
            if ({qa[0], qd[0], qm[0]} !== {20'h00000, 32'hEFBEADDE, 4'b1111}) begin
                nfail++;
                $display("FAIL midrst_after_write: got %h %h %b required 00000 EFBEADDE 1111", qa[0], qd[0], qm[0]);
            end
        end
    endtask

    task automatic test_long_stream();
        logic [31:0] exp_d;
        clear_log();
        start_session(20'h00000);
        send_len(32'd1024);
        for (int i = 0; i < 1024; i++) send_byte(8'(i));
        wait_idle();
        ncmp++;
        if (qa.size() !== 256 || done_cnt !== 1) begin
            nfail++;
            $display("FAIL long_count: writes=%0d dones=%0d required 256 1", qa.size(), done_cnt);
        end else begin
            for (int k = 0; k < 256; k++) begin
                exp_d = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
                ncmp++;
                if ({qa[k], qd[k], qm[k]} !== {20'(4*k), exp_d, 4'b1111}) begin
                    nfail++;
                    $display("FAIL long_w%0d: got %h %h %b required %h %h 1111", k, qa[k], qd[k], qm[k], 20'(4*k), exp_d);
                end
            end
        end
    endtask

    initial begin
        ncmp      = 0;
        nfail     = 0;
        done_cnt  = 0;
        err_cnt   = 0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        rx_data   = '0;
        rx_valid  = 1'b0;
        test_reset();
        test_single_word();
        test_partial_tail();
        test_zero_and_bounds();
        test_flow_control();
        test_reset_mid();
        test_long_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
